// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential word fetch into a DEPTH-entry {pc, instr} ring,
// drained by the core over valid/ready. Optional empty-queue bypass under FETCHQ_BYPASS_EN.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     mem_req,
    output logic [31:0]              mem_addr,
    input  logic                     mem_ack,
    input  logic [31:0]              mem_rdata,
    output logic                     instr_valid,
    output logic [31:0]              instr,
    output logic [31:0]              instr_pc,
    input  logic                     instr_ready,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Handshakes: memory side transfers when mem_req & mem_ack; core side when
    // instr_valid & instr_ready. A raised mem_req only drops on redirect.
    logic [31:0]   fetch_pc;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          run;

    logic [31:0]   pc_mem  [DEPTH];
    logic [31:0]   ins_mem [DEPTH];

    logic full;
    logic empty;
    logic fire;
    logic push;
    logic pop;

    // Low address bits of a redirect target are dropped to force word alignment.
    logic unused_rpc_bits;
    assign unused_rpc_bits = &{1'b0, redirect_pc[1:0]};

    assign full     = (cnt == DEPTH_C);
    assign empty    = (cnt == '0);
    assign mem_req  = run & ~full & ~redirect;
    assign mem_addr = fetch_pc;
    assign fire     = mem_req & mem_ack;
    assign count    = cnt;

`ifdef FETCHQ_BYPASS_EN
    logic bypass;
    assign bypass      = empty & fire;
    assign instr_valid = ~empty | bypass;
    assign pop         = ~empty & instr_ready;
    // A bypassed word taken by the core the same cycle never occupies a slot.
    assign push        = fire & ~(bypass & instr_ready);

    always_comb begin
        instr    = '0;
        instr_pc = '0;
        if (!empty) begin
            instr    = ins_mem[rd_ptr];
            instr_pc = pc_mem[rd_ptr];
        end else if (bypass) begin
            instr    = mem_rdata;
            instr_pc = fetch_pc;
        end
    end
`else
    assign instr_valid = ~empty;
    assign pop         = instr_valid & instr_ready;
    assign push        = fire;

    always_comb begin
        instr    = '0;
        instr_pc = '0;
        if (!empty) begin
            instr    = ins_mem[rd_ptr];
            instr_pc = pc_mem[rd_ptr];
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    // Redirect wins over any ack or pop seen on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
        end else if (redirect) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
        end else begin
            if (fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]  <= fetch_pc;
            ins_mem[wr_ptr] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, hand-written corner sequences, and
// randomized traffic against a queue-based reference model.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   mem_req;
    logic [31:0]            mem_addr;
    logic                   mem_ack = 1'b0;
    logic [31:0]            mem_rdata = '0;
    logic                   instr_valid;
    logic [31:0]            instr;
    logic [31:0]            instr_pc;
    logic                   instr_ready = 1'b0;
    logic                   redirect = 1'b0;
    logic [31:0]            redirect_pc = '0;
    logic [$clog2(DEPTH):0] count;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .count       (count)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_fpc = RESET_PC;
    bit          m_run = 1'b0;

    function automatic logic [31:0] word_at(logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0113;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(bit a, bit r, bit rd, logic [31:0] rp);
        @(negedge clk);
        mem_ack     = a;
        instr_ready = r;
        redirect    = rd;
        redirect_pc = rp;
        mem_rdata   = word_at(m_fpc);
        #1;
    endtask

    function automatic bit exp_req();
        return m_run && (q.size() < DEPTH) && !redirect;
    endfunction

    function automatic bit exp_bypass();
        bit b;
        b = 1'b0;
`ifdef FETCHQ_BYPASS_EN
        b = (q.size() == 0) && exp_req() && mem_ack;
`endif
        return b;
    endfunction

    task automatic model_check();
        int n;
        bit byp;
        n   = q.size();
        byp = exp_bypass();
        chk("mem_req", 32'(mem_req), 32'(exp_req()));
        chk("mem_addr", mem_addr, m_fpc);
        chk("count", 32'(count), 32'(n));
        chk("instr_valid", 32'(instr_valid), 32'((n != 0) || byp));
        if (n != 0) begin
            chk("instr_pc", instr_pc, q[0].pc);
            chk("instr", instr, q[0].ins);
        end else if (byp) begin
            chk("bypass_pc", instr_pc, m_fpc);
            chk("bypass_instr", instr, mem_rdata);
        end
    endtask

    task automatic model_edge();
        bit fire;
        bit byp;
        int n;
        @(posedge clk);
        n    = q.size();
        fire = exp_req() && mem_ack;
        byp  = exp_bypass();
        if (redirect) begin
            q.delete();
            m_fpc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (n != 0 && instr_ready) void'(q.pop_front());
            if (fire && !(byp && instr_ready)) q.push_back('{m_fpc, mem_rdata});
            if (fire) m_fpc = m_fpc + 32'd4;
        end
        m_run = 1'b1;
    endtask

    task automatic step(bit a, bit r, bit rd, logic [31:0] rp);
        drive(a, r, rd, rp);
        model_check();
        model_edge();
    endtask

    // Asserts reset wherever the bench currently is, checks it took effect without a
    // clock edge, then releases it shortly after the next rising edge.
    task automatic do_reset();
        reset       = 1'b1;
        mem_ack     = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        q.delete();
        m_fpc = RESET_PC;
        m_run = 1'b0;
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_addr", mem_addr, RESET_PC);
        chk("rst_instr_valid", 32'(instr_valid), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    typedef struct {
        bit          ack;
        bit          rdy;
        bit          redir;
        logic [31:0] rpc;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
        int          e_cnt;
    } vec_t;

    vec_t tbl[18];

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1, 0, 0, 32'h0,   0, 32'h00,  0, 32'h0,   0};
        tbl[1]  = '{1, 0, 0, 32'h0,   1, 32'h00,  0, 32'h0,   0};
        tbl[2]  = '{1, 0, 0, 32'h0,   1, 32'h04,  1, 32'h0,   1};
        tbl[3]  = '{1, 0, 0, 32'h0,   1, 32'h08,  1, 32'h0,   2};
        tbl[4]  = '{1, 0, 0, 32'h0,   1, 32'h0C,  1, 32'h0,   3};
        tbl[5]  = '{1, 0, 0, 32'h0,   0, 32'h10,  1, 32'h0,   4};
        tbl[6]  = '{1, 1, 0, 32'h0,   0, 32'h10,  1, 32'h0,   4};
        tbl[7]  = '{0, 0, 0, 32'h0,   1, 32'h10,  1, 32'h4,   3};
        tbl[8]  = '{0, 0, 0, 32'h0,   1, 32'h10,  1, 32'h4,   3};
        tbl[9]  = '{0, 0, 0, 32'h0,   1, 32'h10,  1, 32'h4,   3};
        tbl[10] = '{1, 0, 0, 32'h0,   1, 32'h10,  1, 32'h4,   3};
        tbl[11] = '{0, 1, 0, 32'h0,   0, 32'h14,  1, 32'h4,   4};
        tbl[12] = '{1, 0, 0, 32'h0,   1, 32'h14,  1, 32'h8,   3};
        tbl[13] = '{1, 1, 1, 32'h103, 0, 32'h18,  1, 32'h8,   4};
        tbl[14] = '{1, 1, 0, 32'h0,   1, 32'h100, 0, 32'h0,   0};
        tbl[15] = '{1, 1, 0, 32'h0,   1, 32'h104, 1, 32'h100, 1};
        tbl[16] = '{0, 1, 0, 32'h0,   1, 32'h108, 1, 32'h104, 1};
        tbl[17] = '{0, 0, 0, 32'h0,   1, 32'h108, 0, 32'h0,   0};

        do_reset();

`ifndef FETCHQ_BYPASS_EN
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].ack, tbl[i].rdy, tbl[i].redir, tbl[i].rpc);
            chk($sformatf("vec%0d_mem_req", i), 32'(mem_req), 32'(tbl[i].e_req));
            chk($sformatf("vec%0d_mem_addr", i), mem_addr, tbl[i].e_addr);
            chk($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(tbl[i].e_valid));
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
            if (tbl[i].e_valid) begin
                chk($sformatf("vec%0d_pc", i), instr_pc, tbl[i].e_pc);
                chk($sformatf("vec%0d_instr", i), instr, word_at(tbl[i].e_pc));
            end
            model_edge();
        end
`else
        step(1, 0, 0, 32'h0);
        drive(1, 1, 0, 32'h0);
        chk("byp_valid", 32'(instr_valid), 32'h1);
        chk("byp_instr", instr, 32'h0050_0113);
        chk("byp_pc", instr_pc, 32'h0);
        chk("byp_count", 32'(count), 32'h0);
        model_edge();
        drive(0, 0, 0, 32'h0);
        chk("byp_count_after", 32'(count), 32'h0);
        chk("byp_addr_after", mem_addr, 32'h4);
        model_edge();
`endif

        // Fill to three entries, then reset mid-stream.
        step(0, 0, 1, 32'h0000_0200);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 32'h0);
        drive(0, 0, 0, 32'h0);
        chk("pre_reset_count", 32'(count), 32'h3);
        do_reset();
        step(0, 0, 0, 32'h0);
        drive(0, 0, 0, 32'h0);
        chk("restart_req", 32'(mem_req), 32'h1);
        chk("restart_addr", mem_addr, RESET_PC);
        model_edge();

        // Back-to-back redirects: the later target wins.
        step(1, 1, 1, 32'h0000_0200);
        step(1, 1, 1, 32'h0000_0301);
        drive(0, 0, 0, 32'h0);
        chk("redir_last_addr", mem_addr, 32'h0000_0300);
        chk("redir_last_req", 32'(mem_req), 32'h1);
        model_edge();

        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 24) == 0,
                 $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
